// File: rtl/flash_pkg.sv
// Shared types and constants for the SPI NOR flash read arbiter.
// Holds the FSM state enum, port IDs, READ opcode and bit counts.
package flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LD = 1'b1
    } port_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam int         CMD_BITS  = 8;
    localparam int         ADDR_BITS = 24;
    localparam int         DATA_BITS = 32;
    localparam int         CNT_W     = 6;

    // Flash returns byte 0 first; it lands in the low byte of the word.
    function automatic logic [31:0] le_word(input logic [31:0] rx);
        return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    endfunction

endpackage

// File: rtl/flash_spi_shifter.sv
// Mode-0 SPI bit engine: divider, SCK, TX/RX shift registers, bit count.
// A start in the done cycle chains the next field with no gap in SCK.
module flash_spi_shifter
    import flash_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] tx_bits,
    input  logic [31:0]      tx_data,
    output logic             done,
    output logic             active,
    output logic [31:0]      rx_data,
    output logic             spi_sck,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    logic             r_active;
    logic             r_sck;
    logic [DW-1:0]    r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_tx;
    logic [31:0]      r_rx;
    logic             w_edge;
    logic             w_last;

    assign w_edge   = r_active && (r_div == DIV_MAX);
    assign w_last   = r_cnt == CNT_W'(1);
    assign done     = w_edge && r_sck && w_last;
    assign active   = r_active;
    assign rx_data  = r_rx;
    assign spi_sck  = r_sck;
    assign spi_mosi = r_tx[31];

    // Half-period divider; sample MISO on rise, shift TX on fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_sck    <= 1'b0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
        end else if (!r_active) begin
            if (start) begin
                r_active <= 1'b1;
                r_sck    <= 1'b0;
                r_div    <= '0;
                r_cnt    <= tx_bits;
                r_tx     <= tx_data;
            end
        end else if (w_edge) begin
            r_div <= '0;
            if (!r_sck) begin
                r_sck <= 1'b1;
                r_rx  <= {r_rx[30:0], spi_miso};
            end else begin
                r_sck <= 1'b0;
                if (done && start) begin
                    r_cnt <= tx_bits;
                    r_tx  <= tx_data;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    r_tx  <= {r_tx[30:0], 1'b0};
                    if (done) begin
                        r_active <= 1'b0;
                    end
                end
            end
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one SPI NOR flash between fetch and load ports.
// Each grant issues READ 0x03 + 24-bit address and returns one LE word.
module flash_read_arbiter
    import flash_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int ADDR_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_ack,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              spi_csb,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int AW = (ADDR_W < ADDR_BITS) ? ADDR_W : ADDR_BITS;

    state_t           r_state;
    port_t            r_port;
    port_t            r_last;
    logic [23:0]      r_addr;
    logic             r_if_ack;
    logic             r_ld_ack;
    logic             r_busy;
    logic             r_csb;
    logic [31:0]      r_rdata;

    logic             w_any;
    logic             w_grant_ld;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [23:0]      w_addr_ext;
    logic             w_start;
    logic [CNT_W-1:0] w_tx_bits;
    logic [31:0]      w_tx_data;
    logic             w_done;
    logic             w_active;
    logic [31:0]      w_rx;

    assign if_ack  = r_if_ack;
    assign ld_ack  = r_ld_ack;
    assign rdata   = r_rdata;
    assign busy    = r_busy;
    assign spi_csb = r_csb;

    // Round-robin pick: on a tie the port not served last wins.
    always_comb begin
        w_any      = if_req | ld_req;
        w_grant_ld = ld_req && (!if_req || (r_last == PORT_IF));
        w_sel_addr = w_grant_ld ? ld_addr : if_addr;
        w_addr_ext = '0;
        w_addr_ext[AW-1:0] = w_sel_addr[AW-1:0];
        w_addr_ext[1:0] = 2'b00;
    end

    // Field sequencing: each field is loaded as the previous one ends.
    always_comb begin
        w_start   = 1'b0;
        w_tx_bits = '0;
        w_tx_data = '0;
        case (r_state)
            ST_IDLE: begin
                w_start   = w_any;
                w_tx_bits = CNT_W'(CMD_BITS);
                w_tx_data = {CMD_READ, 24'h0};
            end
            ST_CMD: begin
                w_start   = w_done;
                w_tx_bits = CNT_W'(ADDR_BITS);
                w_tx_data = {r_addr, 8'h00};
            end
            ST_ADDR: begin
                w_start   = w_done;
                w_tx_bits = CNT_W'(DATA_BITS);
                w_tx_data = '0;
            end
            default: ;
        endcase
    end

    // Transaction FSM with registered acks, busy, chip select and data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_port   <= PORT_IF;
            r_last   <= PORT_IF;
            r_addr   <= '0;
            r_if_ack <= 1'b0;
            r_ld_ack <= 1'b0;
            r_busy   <= 1'b0;
            r_csb    <= 1'b1;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_port  <= w_grant_ld ? PORT_LD : PORT_IF;
                        r_addr  <= w_addr_ext;
                        r_busy  <= 1'b1;
                        r_csb   <= 1'b0;
                        r_state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (w_done) begin
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_done) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!w_active) begin
                        r_csb    <= 1'b1;
                        r_if_ack <= (r_port == PORT_IF);
                        r_ld_ack <= (r_port == PORT_LD);
                        r_rdata  <= le_word(w_rx);
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_if_ack <= 1'b0;
                    r_ld_ack <= 1'b0;
                    r_busy   <= 1'b0;
                    r_last   <= r_port;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    flash_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_start),
        .tx_bits  (w_tx_bits),
        .tx_data  (w_tx_data),
        .done     (w_done),
        .active   (w_active),
        .rx_data  (w_rx),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

endmodule
